// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life run controller: grid size,
// controller state encoding and run status codes.
package life_pkg;

    localparam int GRID_BITS = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'b00,
        STAT_LIMIT   = 2'b01,
        STAT_EXTINCT = 2'b10,
        STAT_STABLE  = 2'b11
    } status_t;

endpackage

// File: rtl/life_frame_cmp.sv
// Frame comparator: flags an empty grid and a grid identical to the
// previous generation.
module life_frame_cmp
    import life_pkg::*;
(
    input  logic [GRID_BITS-1:0] cur,
    input  logic [GRID_BITS-1:0] prev,
    output logic                 is_zero,
    output logic                 is_equal
);

    assign is_zero  = (cur == '0);
    assign is_equal = (cur == prev);

endmodule

// File: rtl/life_run_ctrl.sv
// Run controller for a 16x16 toroidal life engine: seeds the engine, steps it
// until extinction, a still life, or the generation limit, and reports why.
module life_run_ctrl
    import life_pkg::*;
#(
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pause,
    input  logic [GRID_BITS-1:0] seed,
    input  logic [GEN_W-1:0]     gen_limit,
    input  logic [GRID_BITS-1:0] life_q,
    output logic                 life_load,
    output logic [GRID_BITS-1:0] life_data,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [GEN_W-1:0]     gen_count
);

    localparam logic [GEN_W-1:0] GEN_ONE = {{(GEN_W-1){1'b0}}, 1'b1};

    state_t                 state, state_d;
    status_t                status_r, status_d;
    logic [GEN_W-1:0]       gen_q, gen_d, gen_inc, limit_reg;
    logic [GRID_BITS-1:0]   seed_reg, prev_q;
    logic                   capture, prev_upd;
    logic                   is_zero, is_equal;

    life_frame_cmp u_cmp (
        .cur      (life_q),
        .prev     (prev_q),
        .is_zero  (is_zero),
        .is_equal (is_equal)
    );

    assign gen_inc = gen_q + GEN_ONE;

    // NOTE: every signal assigned in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        status_d = status_r;
        gen_d    = gen_q;
        capture  = 1'b0;
        prev_upd = 1'b0;
        if (abort) begin
            state_d  = ST_IDLE;
            status_d = STAT_NONE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        capture  = 1'b1;
                        gen_d    = '0;
                        status_d = STAT_NONE;
                        state_d  = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (limit_reg == '0) begin
                        state_d  = ST_DONE;
                        status_d = STAT_LIMIT;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // While paused the engine reloads its own output, so nothing here may advance.
                    if (!pause) begin
                        prev_upd = 1'b1;
                        if (is_zero) begin
                            state_d  = ST_DONE;
                            status_d = STAT_EXTINCT;
                        end else if (gen_q != '0 && is_equal) begin
                            state_d  = ST_DONE;
                            status_d = STAT_STABLE;
                        end else if (gen_inc == limit_reg) begin
                            gen_d    = gen_inc;
                            state_d  = ST_DONE;
                            status_d = STAT_LIMIT;
                        end else begin
                            gen_d    = gen_inc;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    // NOTE: the wide seed and frame registers are plain flops, not memories, so they are reset along with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            status_r  <= STAT_NONE;
            gen_q     <= '0;
            limit_reg <= '0;
            seed_reg  <= '0;
            prev_q    <= '0;
        end else begin
            state    <= state_d;
            status_r <= status_d;
            gen_q    <= gen_d;
            if (capture) begin
                seed_reg  <= seed;
                limit_reg <= gen_limit;
            end
            if (prev_upd) begin
                prev_q <= life_q;
            end
        end
    end

    assign life_load = (state != ST_RUN) | pause;
    assign life_data = (state == ST_LOAD) ? seed_reg : life_q;
    assign busy      = (state == ST_LOAD) | (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign status    = status_r;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_run_ctrl.sv
// Bench for life_run_ctrl with a behavioural 16x16 toroidal life engine
// wired to the controller's load port.
module tb_life_run_ctrl;

    localparam int GEN_W = 16;

    typedef struct {
        logic [255:0]     seed;
        logic [GEN_W-1:0] limit;
        logic [1:0]       exp_status;
        logic [GEN_W-1:0] exp_gen;
        logic [255:0]     exp_q;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             pause;
    logic [255:0]     seed;
    logic [GEN_W-1:0] gen_limit;
    logic [255:0]     life_q = '0;
    logic             life_load;
    logic [255:0]     life_data;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [GEN_W-1:0] gen_count;

    int errors = 0;
    int checks = 0;

    life_run_ctrl #(.GEN_W(GEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pause     (pause),
        .seed      (seed),
        .gen_limit (gen_limit),
        .life_q    (life_q),
        .life_load (life_load),
        .life_data (life_data),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] life_next(input logic [255:0] g);
        logic [255:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0)
                            cnt += int'(g[((r + dr + 16) % 16) * 16 + ((c + dc + 16) % 16)]);
                    end
                end
                n[r*16+c] = g[r*16+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    // Engine: reloads life_data when strobed, otherwise advances one generation.
    always @(posedge clk) begin
        if (life_load) life_q <= life_data;
        else           life_q <= life_next(life_q);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_gen(input logic [GEN_W-1:0] n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy && gen_count == n) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic kick(input logic [255:0] s, input logic [GEN_W-1:0] lim);
        @(negedge clk);
        seed      = s;
        gen_limit = lim;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    vec_t         vecs[9];
    logic [255:0] blk, hblink, vblink, q_snap;
    bit           ok;

    initial begin
        blk    = '0; blk[17] = 1'b1; blk[18] = 1'b1; blk[33] = 1'b1; blk[34] = 1'b1;
        hblink = '0; hblink[84] = 1'b1; hblink[85] = 1'b1; hblink[86] = 1'b1;
        vblink = '0; vblink[69] = 1'b1; vblink[85] = 1'b1; vblink[101] = 1'b1;

        vecs[0] = '{256'd0, 16'd10, 2'b10, 16'd0, 256'd0};
        vecs[1] = '{256'd1, 16'd10, 2'b10, 16'd1, 256'd0};
        vecs[2] = '{blk,    16'd10, 2'b11, 16'd1, blk};
        vecs[3] = '{hblink, 16'd5,  2'b01, 16'd5, vblink};
        vecs[4] = '{hblink, 16'd0,  2'b01, 16'd0, hblink};
        vecs[5] = '{hblink, 16'd1,  2'b01, 16'd1, vblink};
        vecs[6] = '{hblink, 16'd4,  2'b01, 16'd4, hblink};
        vecs[7] = '{blk,    16'd1,  2'b01, 16'd1, blk};
        vecs[8] = '{256'd0, 16'd0,  2'b01, 16'd0, 256'd0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        seed = '0; gen_limit = '0;
        #1;
        check("reset life_load", life_load, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset status", status, 0);
        check("reset gen_count", gen_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            kick(vecs[i].seed, vecs[i].limit);
            check($sformatf("vec%0d load busy", i), busy, 1);
            check($sformatf("vec%0d load status", i), status, 0);
            wait_done(ok);
            check($sformatf("vec%0d reached done", i), ok, 1);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d done held", i), done, 1);
            check($sformatf("vec%0d status", i), status, vecs[i].exp_status);
            check($sformatf("vec%0d gen_count", i), gen_count, vecs[i].exp_gen);
            check($sformatf("vec%0d life_q", i), life_q, vecs[i].exp_q);
        end

        // Pause for three cycles at generation 2 of a blinker run.
        kick(hblink, 16'd5);
        wait_gen(16'd2, ok);
        check("pause reach gen2", ok, 1);
        check("pause gen2 grid", life_q, hblink);
        q_snap = life_q;
        pause  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("pause%0d gen_count", k), gen_count, 2);
            check($sformatf("pause%0d life_q", k), life_q, q_snap);
            check($sformatf("pause%0d busy", k), busy, 1);
        end
        pause = 1'b0;
        wait_done(ok);
        check("pause reached done", ok, 1);
        check("pause final status", status, 2'b01);
        check("pause final gen_count", gen_count, 5);
        check("pause final life_q", life_q, vblink);

        // Abort at generation 3 together with a start: abort wins.
        kick(hblink, 16'd20);
        wait_gen(16'd3, ok);
        check("abort reach gen3", ok, 1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort status", status, 0);
        @(negedge clk);
        check("abort stays idle", busy, 0);

        // Start is ignored mid-run; then reset mid-run freezes the engine.
        kick(hblink, 16'd20);
        wait_gen(16'd1, ok);
        check("run2 reach gen1", ok, 1);
        seed  = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_gen(16'd3, ok);
        check("run2 reach gen3", ok, 1);
        check("run2 start ignored", life_q, vblink);
        q_snap = life_q;
        rst_n  = 1'b0;
        #1;
        check("rst busy", busy, 0);
        check("rst life_load", life_load, 1);
        check("rst status", status, 0);
        check("rst gen_count", gen_count, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst%0d life_q frozen", k), life_q, q_snap);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst busy", busy, 0);
        check("post-rst done", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
